// File: rtl/rx_clk_pkg.sv
// Shared definitions for the rx clock lock manager.
//   - State encoding: fixed numeric values, visible on state_o.
//   - clog2_f: counter width helper. Always returns at least 1.
package rx_clk_pkg;

   localparam logic [2:0] ST_RESET_DCM = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RELEASE   = 3'd3;
   localparam logic [2:0] ST_RUN       = 3'd4;
   localparam logic [2:0] ST_FAIL      = 3'd5;

   typedef enum logic [2:0] {
      RESET_DCM = ST_RESET_DCM,
      WAIT_LOCK = ST_WAIT_LOCK,
      STABLE    = ST_STABLE,
      RELEASE   = ST_RELEASE,
      RUN       = ST_RUN,
      FAIL      = ST_FAIL
   } state_t;

   // Bits needed to hold values 0 .. value-1.
   // Never returns 0, so the result is always a legal vector width.
   function automatic int clog2_f(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/rx_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low clear of the whole chain
//   clr    in   synchronous clear: every flop loads 0 on the next edge
//   d      in   asynchronous input level
//   q      out  synchronised level, STAGES edges behind d
module rx_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else if (clr) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rx_clk_lock_mgr.sv
// Supervises the rx DCM and sequences per-domain resets.
//
// The manager pulses the DCM reset and waits for a stable lock. It then
// releases the downstream domains one at a time. If lock never arrives, or
// is later lost, it retries the DCM. After too many retries it parks in FAIL.
//
// Ports (all outputs registered):
//   rxclk         in   free-running clock (not a DCM output)
//   reset_n       in   asynchronous active-low reset
//   locked_in     in   DCM LOCKED, asynchronous to rxclk
//   restart       in   one-cycle request: full restart, clears retry_cnt/lock_lost
//   dcm_rst       out  DCM reset, high in RESET_DCM and FAIL
//   dom_rst       out  per-domain reset, active high, bit 0 released first
//   all_released  out  high in RUN only
//   state_o       out  current state encoding
//   retry_cnt     out  retries since reset/restart, saturating at MAX_RETRIES
//   lock_lost     out  sticky: lock dropped during RELEASE or RUN
//   fail          out  high in FAIL
module rx_clk_lock_mgr
   import rx_clk_pkg::*;
#(
   parameter int N_DOMAINS     = 2,
   parameter int RST_PULSE     = 3,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STAGGER       = 16,
   parameter int MAX_RETRIES   = 7,
   parameter int SYNC_STAGES   = 2,
   localparam int RW           = clog2_f(MAX_RETRIES + 1)
) (
   input  logic                 rxclk,
   input  logic                 reset_n,
   input  logic                 locked_in,
   input  logic                 restart,
   output logic                 dcm_rst,
   output logic [N_DOMAINS-1:0] dom_rst,
   output logic                 all_released,
   output logic [2:0]           state_o,
   output logic [RW-1:0]        retry_cnt,
   output logic                 lock_lost,
   output logic                 fail
);

   // One shared counter measures the DCM reset pulse and then the release stagger.
   localparam int REL_LAST = STAGGER * (N_DOMAINS - 1);
   localparam int CNT_MAX  = (RST_PULSE - 1 > REL_LAST) ? RST_PULSE - 1 : REL_LAST;
   localparam int CW       = clog2_f(CNT_MAX + 1);
   localparam int SW       = clog2_f(STABLE_CYCLES);
   localparam int TW       = clog2_f(LOCK_TIMEOUT);

   localparam logic [CW-1:0] PULSE_END   = CW'(RST_PULSE - 1);
   localparam logic [CW-1:0] REL_END     = CW'(REL_LAST);
   localparam logic [SW-1:0] STABLE_END  = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_END = TW'(LOCK_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   state_t               state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [SW-1:0]        scnt, scnt_nx;
   logic [TW-1:0]        tcnt, tcnt_nx;
   logic [RW-1:0]        retry_nx;
   logic                 lost_nx;
   logic                 take_retry;
   logic                 timed_out;
   logic                 lock_s;
   logic                 dcm_rst_nx;
   logic [N_DOMAINS-1:0] dom_rst_nx;

   // The clear uses the next-state value of dcm_rst. This keeps the chain
   // reading 0 in every cycle that dcm_rst is high. It also lets the chain
   // start capturing on the edge that leaves RESET_DCM.
   rx_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (rxclk),
      .rst_n (reset_n),
      .clr   (dcm_rst_nx),
      .d     (locked_in),
      .q     (lock_s)
   );

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      scnt_nx    = scnt;
      tcnt_nx    = tcnt;
      retry_nx   = retry_cnt;
      lost_nx    = lock_lost;
      take_retry = 1'b0;
      timed_out  = (tcnt == TIMEOUT_END);

      case (state)
         RESET_DCM: begin
            scnt_nx = '0;
            tcnt_nx = '0;
            if (cnt == PULSE_END) begin
               cnt_nx   = '0;
               state_nx = WAIT_LOCK;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WAIT_LOCK: begin
            tcnt_nx    = tcnt + 1'b1;
            take_retry = timed_out;
            if (lock_s) state_nx = STABLE;
         end
         STABLE: begin
            tcnt_nx = tcnt + 1'b1;
            if (!lock_s) begin
               scnt_nx    = '0;
               state_nx   = WAIT_LOCK;
               take_retry = timed_out;
            end else if (scnt == STABLE_END) begin
               // Completing on the final allowed cycle still counts as in time.
               scnt_nx  = '0;
               cnt_nx   = '0;
               state_nx = RELEASE;
            end else begin
               scnt_nx    = scnt + 1'b1;
               take_retry = timed_out;
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               lost_nx    = 1'b1;
               take_retry = 1'b1;
            end else if (cnt == REL_END) begin
               cnt_nx   = '0;
               state_nx = RUN;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               lost_nx    = 1'b1;
               take_retry = 1'b1;
            end
         end
         FAIL: begin
            state_nx = FAIL;
         end
         default: begin
            state_nx = RESET_DCM;
         end
      endcase

      if (take_retry) begin
         cnt_nx  = '0;
         scnt_nx = '0;
         tcnt_nx = '0;
         if (retry_cnt < RETRY_MAX) begin
            retry_nx = retry_cnt + 1'b1;
            state_nx = RESET_DCM;
         end else begin
            state_nx = FAIL;
         end
      end

      // A restart overrides any retry or lock-loss decision made this cycle.
      if (restart) begin
         state_nx = RESET_DCM;
         cnt_nx   = '0;
         scnt_nx  = '0;
         tcnt_nx  = '0;
         retry_nx = '0;
         lost_nx  = 1'b0;
      end

      dcm_rst_nx = (state_nx == RESET_DCM) || (state_nx == FAIL);

      // In RELEASE, cnt_nx is the number of cycles already spent in RELEASE.
      // Domain i is released once that count reaches STAGGER*i.
      for (int i = 0; i < N_DOMAINS; i++) begin
         dom_rst_nx[i] = !((state_nx == RUN) ||
                           ((state_nx == RELEASE) && (cnt_nx >= CW'(STAGGER * i))));
      end
   end

   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RESET_DCM;
         cnt          <= '0;
         scnt         <= '0;
         tcnt         <= '0;
         retry_cnt    <= '0;
         lock_lost    <= 1'b0;
         dcm_rst      <= 1'b1;
         dom_rst      <= '1;
         all_released <= 1'b0;
         fail         <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         scnt         <= scnt_nx;
         tcnt         <= tcnt_nx;
         retry_cnt    <= retry_nx;
         lock_lost    <= lost_nx;
         dcm_rst      <= dcm_rst_nx;
         dom_rst      <= dom_rst_nx;
         all_released <= (state_nx == RUN);
         fail         <= (state_nx == FAIL);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_rx_clk_lock_mgr.sv
// Self-checking bench for rx_clk_lock_mgr.
// The reference model tracks the phase and the entry timestamps of each
// phase, then derives every output from those timestamps. It is compared
// with the DUT at each falling edge. Directed literal checks pin the
// important cycle positions.
module tb_rx_clk_lock_mgr;

   localparam int N     = 3;
   localparam int PULSE = 3;
   localparam int STAB  = 8;
   localparam int TOUT  = 32;
   localparam int STAG  = 4;
   localparam int MAXR  = 2;
   localparam int SYNC  = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       locked_in;
   logic       restart;
   logic       dcm_rst;
   logic [2:0] dom_rst;
   logic       all_released;
   logic [2:0] state_o;
   logic [1:0] retry_cnt;
   logic       lock_lost;
   logic       fail;

   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   rx_clk_lock_mgr #(
      .N_DOMAINS     (N),
      .RST_PULSE     (PULSE),
      .STABLE_CYCLES (STAB),
      .LOCK_TIMEOUT  (TOUT),
      .STAGGER       (STAG),
      .MAX_RETRIES   (MAXR),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .rxclk        (clk),
      .reset_n      (reset_n),
      .locked_in    (locked_in),
      .restart      (restart),
      .dcm_rst      (dcm_rst),
      .dom_rst      (dom_rst),
      .all_released (all_released),
      .state_o      (state_o),
      .retry_cnt    (retry_cnt),
      .lock_lost    (lock_lost),
      .fail         (fail)
   );

   // ---------------- reference model ----------------
   // Phase codes follow the state_o encoding: 0 RESET_DCM .. 5 FAIL.
   int              m_ph, m_cyc, t_ph, t_to, t_stab, t_rel, m_retry;
   bit              m_lost;
   logic [SYNC-1:0] m_sq;
   logic [2:0]      e_state, e_dom;
   logic            e_dcm, e_all, e_lost, e_fail;
   logic [1:0]      e_retry;

   task automatic model_outputs(input int rel_age);
      e_state = 3'(m_ph);
      e_dcm   = (m_ph == 0) || (m_ph == 5);
      e_fail  = (m_ph == 5);
      e_all   = (m_ph == 4);
      e_retry = 2'(m_retry);
      e_lost  = m_lost;
      for (int i = 0; i < N; i++)
         e_dom[i] = !((m_ph == 4) || ((m_ph == 3) && (rel_age >= STAG * i)));
   endtask

   task automatic model_reset();
      m_ph = 0; m_cyc = 0; t_ph = 0; t_to = 0; t_stab = 0; t_rel = 0;
      m_retry = 0; m_lost = 0; m_sq = '0;
      model_outputs(0);
   endtask

   task automatic model_step();
      int   nph;
      logic ls;
      bit   go;
      ls  = m_sq[SYNC-1];
      nph = m_ph;
      go  = 0;
      case (m_ph)
         0: if (m_cyc - t_ph == PULSE - 1) begin nph = 1; t_to = m_cyc + 1; end
         1: if (ls) begin nph = 2; t_stab = m_cyc + 1; end
         2: if (!ls) nph = 1;
            else if (m_cyc - t_stab + 1 == STAB) begin nph = 3; t_rel = m_cyc + 1; end
         3: if (!ls) begin go = 1; m_lost = 1; end
            else if (m_cyc - t_rel == STAG * (N - 1)) nph = 4;
         4: if (!ls) begin go = 1; m_lost = 1; end
         default: ;
      endcase
      if ((m_ph == 1 || m_ph == 2) && nph != 3 && (m_cyc - t_to + 1 >= TOUT)) go = 1;
      if (go) begin
         if (m_retry < MAXR) begin m_retry++; nph = 0; end
         else nph = 5;
      end
      if (restart) begin nph = 0; m_retry = 0; m_lost = 0; end
      if (nph == 0 && (m_ph != 0 || restart)) t_ph = m_cyc + 1;
      if (nph == 0 || nph == 5) m_sq = '0;
      else m_sq = {m_sq[SYNC-2:0], locked_in};
      m_ph = nph;
      model_outputs(m_cyc + 1 - t_rel);
      m_cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Output order: state, dcm_rst, dom_rst, all_released, retry_cnt, lock_lost, fail.
   initial begin
      forever begin
         @(negedge clk);
         check("model_cmp",
               {state_o, dcm_rst, dom_rst, all_released, retry_cnt, lock_lost, fail},
               {e_state, e_dcm, e_dom, e_all, e_retry, e_lost, e_fail});
      end
   end

   // ---------------- driver ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; restart = 1'b0; locked_in = 1'b1;
      tick(3);
      reset_n = 1'b1;                       // cycle 0
      // Test 1: clean bring-up.
      check("rst_state", state_o, 0);
      check("rst_dcm", dcm_rst, 1);
      check("rst_dom", dom_rst, 3'b111);
      check("rst_diag", {retry_cnt, lock_lost, fail, all_released}, 0);
      tick(2);  check("t1_dcm_c2", dcm_rst, 1);
      tick(1);  check("t1_wait_c3", {state_o, dcm_rst}, {3'd1, 1'b0});
      tick(2);  check("t1_stable_c5", state_o, 2);
      tick(7);  check("t1_stable_c12", state_o, 2);
      tick(1);  check("t1_rel_c13", {state_o, dom_rst}, {3'd3, 3'b110});
      tick(4);  check("t1_dom_c17", dom_rst, 3'b100);
      tick(4);  check("t1_dom_c21", {dom_rst, all_released}, {3'b000, 1'b0});
      tick(1);  check("t1_run_c22", {state_o, all_released, retry_cnt}, {3'd4, 1'b1, 2'd0});
      // Test 3: one-cycle lock drop in RUN (cycle 22).
      locked_in = 1'b0;
      tick(1);  locked_in = 1'b1;           // 23
      tick(1);  check("t3_still_run", {dom_rst, all_released}, {3'b000, 1'b1});
      tick(1);  check("t3_loss", {state_o, dom_rst, all_released, lock_lost, retry_cnt},
                      {3'd0, 3'b111, 1'b0, 1'b1, 2'd1});
      tick(22); check("t3_relock_run", {state_o, lock_lost, retry_cnt}, {3'd4, 1'b1, 2'd1});
      // Test 4: restart at 47, glitch at STABLE count 5.
      restart = 1'b1;
      tick(1);  restart = 1'b0;             // 48
      check("t4_restart", {state_o, retry_cnt, lock_lost, dom_rst}, {3'd0, 2'd0, 1'b0, 3'b111});
      tick(8);  locked_in = 1'b0;           // 56
      tick(1);  locked_in = 1'b1;           // 57
      tick(1);  check("t4_glitch_seen", state_o, 2);
      tick(1);  check("t4_back_wait", state_o, 1);
      tick(1);  check("t4_restable", state_o, 2);
      tick(7);  check("t4_full_count", {state_o, dom_rst, retry_cnt}, {3'd2, 3'b111, 2'd0});
      tick(1);  check("t4_release", {state_o, dom_rst}, {3'd3, 3'b110});
      tick(9);  check("t4_run", state_o, 4);  // 77
      // Test 2: no lock, retries into FAIL.
      restart = 1'b1; locked_in = 1'b0;
      tick(1);  restart = 1'b0;             // 78
      tick(3);  check("t2_wait", {state_o, dcm_rst}, {3'd1, 1'b0});
      tick(31); check("t2_last_wait", {state_o, retry_cnt}, {3'd1, 2'd0});
      tick(1);  check("t2_retry1", {state_o, retry_cnt, dcm_rst}, {3'd0, 2'd1, 1'b1});
      tick(35); check("t2_retry2", {state_o, retry_cnt}, {3'd0, 2'd2});
      tick(34); check("t2_last_wait3", state_o, 1);
      tick(1);  check("t2_fail", {state_o, fail, dcm_rst, dom_rst, retry_cnt},
                      {3'd5, 1'b1, 1'b1, 3'b111, 2'd2});
      tick(5);  check("t2_fail_hold", {state_o, fail}, {3'd5, 1'b1});
      // Test 5: restart with a lock edge (cycle 188).
      restart = 1'b1; locked_in = 1'b1;
      tick(1);  restart = 1'b0;
      check("t5_restart", {state_o, retry_cnt, fail, dcm_rst}, {3'd0, 2'd0, 1'b0, 1'b1});
      tick(2);  check("t5_dcm_c3", dcm_rst, 1);
      tick(1);  check("t5_wait", {state_o, dcm_rst}, {3'd1, 1'b0});
      tick(2);  check("t5_stable", state_o, 2);
      tick(8);  check("t5_release", {state_o, dom_rst}, {3'd3, 3'b110});
      tick(4);  check("t5_dom_100", dom_rst, 3'b100);
      // Test 6: asynchronous reset mid-RELEASE, away from any clock edge.
      #2 reset_n = 1'b0;
      #1 check("t6_async", {state_o, dcm_rst, dom_rst, all_released, retry_cnt, lock_lost, fail},
               {3'd0, 1'b1, 3'b111, 1'b0, 2'd0, 1'b0, 1'b0});
      tick(2);
      reset_n = 1'b1;
      tick(22); check("t6_rerun", {state_o, all_released, dom_rst}, {3'd4, 1'b1, 3'b000});
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
